led_spi_cmd_ctrl: RTL

Command sequencer between the external SPI link and the LED frame buffer. It deserializes SPI words (mode 0, MSB first, active-low enable), decodes a header word per transaction, and drives auto-incrementing writes into the back bank of a double-buffered pixel RAM. It also schedules bank swaps on the display's frame-sync pulse so the panel never shows a half-written frame.

---
 rtl/led_spi_cmd_ctrl_pkg.sv | 23 ++
 rtl/led_spi_cmd_ctrl_if.sv | 16 +
 rtl/led_spi_cmd_ctrl_spi_word_rx.sv | 88 ++++++++
 rtl/led_spi_cmd_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/led_spi_cmd_ctrl_pkg.sv
// Shared definitions for the LED SPI command sequencer.
// Holds the header opcode values, the position of the opcode field in the
// header word, and the encoding of the command FSM states.
package led_spi_pkg;

  // Opcode field location inside the header word (upper nibble of 16 bits)
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;

  localparam opcode_t OP_NOP   = 4'h0;
  localparam opcode_t OP_WRITE = 4'h1;
  localparam opcode_t OP_SWAP  = 4'h2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/led_spi_cmd_ctrl_if.sv
// Pixel RAM write bus driven by the command sequencer.
//   o_WR_EN   : one-cycle write strobe
//   o_WR_ADDR : {back bank, pixel address}
//   o_WR_DATA : pixel word (valid only while o_WR_EN=1)
// master = sequencer side, slave = frame buffer side.
interface led_spi_cmd_ctrl_if #(
  parameter int BIT_WIDTH = 16,
  parameter int ADDR_W    = 10
);
  logic                 o_WR_EN;
  logic [ADDR_W:0]      o_WR_ADDR;
  logic [BIT_WIDTH-1:0] o_WR_DATA;

  modport master (output o_WR_EN, o_WR_ADDR, o_WR_DATA);
  modport slave  (input  o_WR_EN, o_WR_ADDR, o_WR_DATA);
endinterface

// File: rtl/led_spi_cmd_ctrl_spi_word_rx.sv
// SPI word deserializer (mode 0, MSB first, active-low enable).
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   spi_clk/ena/dat : asynchronous SPI inputs
//   word_stb      : one-cycle pulse, word holds a complete received word
//   ena_fall/rise : one-cycle pulses on synchronized enable edges
//   partial       : valid with ena_rise; a word was cut short
module spi_word_rx #(
  parameter int BIT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_clk,
  input  logic                 spi_ena,
  input  logic                 spi_dat,
  output logic                 word_stb,
  output logic [BIT_WIDTH-1:0] word,
  output logic                 ena_fall,
  output logic                 ena_rise,
  output logic                 partial
);
  localparam int CNT_W = $clog2(BIT_WIDTH);

  logic [SYNC_STAGES-1:0] sclk_sync_reg, ena_sync_reg, dat_sync_reg;
  logic                   sclk_prev_reg, ena_prev_reg;
  logic                   active_reg;
  logic [BIT_WIDTH-1:0]   shift_reg;
  logic [CNT_W-1:0]       cnt_reg;

  logic sclk_s, ena_s, dat_s;
  logic sclk_rise, ena_fall_c, ena_rise_c;

  assign sclk_s     = sclk_sync_reg[SYNC_STAGES-1];
  assign ena_s      = ena_sync_reg[SYNC_STAGES-1];
  assign dat_s      = dat_sync_reg[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_prev_reg;
  assign ena_fall_c = ~ena_s & ena_prev_reg;
  assign ena_rise_c = ena_s & ~ena_prev_reg;

  // The enable synchronizer resets to 0 ("enabled"): if ENA is already low
  // when reset releases, no falling edge can be seen until ENA has first been
  // observed high, so a transaction cut by reset is ignored to its end.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_reg <= '0;
      ena_sync_reg  <= '0;
      dat_sync_reg  <= '0;
      sclk_prev_reg <= 1'b0;
      ena_prev_reg  <= 1'b0;
      active_reg    <= 1'b0;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      word_stb      <= 1'b0;
      word          <= '0;
      ena_fall      <= 1'b0;
      ena_rise      <= 1'b0;
      partial       <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_clk};
      ena_sync_reg  <= {ena_sync_reg[SYNC_STAGES-2:0], spi_ena};
      dat_sync_reg  <= {dat_sync_reg[SYNC_STAGES-2:0], spi_dat};
      sclk_prev_reg <= sclk_s;
      ena_prev_reg  <= ena_s;
      word_stb      <= 1'b0;
      ena_fall      <= ena_fall_c;
      ena_rise      <= ena_rise_c;
      partial       <= ena_rise_c && (cnt_reg != '0);
      if (ena_fall_c) begin
        active_reg <= 1'b1;
        shift_reg  <= '0;
        cnt_reg    <= '0;
      end else if (ena_rise_c) begin
        active_reg <= 1'b0;
        cnt_reg    <= '0;
      end else if (active_reg && sclk_rise) begin
        shift_reg <= {shift_reg[BIT_WIDTH-2:0], dat_s};
        if (cnt_reg == CNT_W'(BIT_WIDTH - 1)) begin
          cnt_reg  <= '0;
          word_stb <= 1'b1;
          word     <= {shift_reg[BIT_WIDTH-2:0], dat_s};
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/led_spi_cmd_ctrl.sv
// LED SPI command sequencer: decodes SPI header words, streams pixel words
// into the back bank of a double-buffered frame RAM and swaps banks on the
// display frame-sync pulse.
// Ports:
//   i_CLK, i_RST         : system clock, synchronous active-high reset
//   i_SPI_CLK/ENA/DAT    : asynchronous SPI link
//   i_FRAME_SYNC         : frame boundary pulse from the scanner
//   i_ERR_CLR            : clears the sticky error
//   wr                   : pixel RAM write bus (master)
//   o_BANK, o_BUSY, o_ERR: displayed bank, transaction active, sticky error
module led_spi_cmd_ctrl
  import led_spi_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_SPI_CLK,
  input  logic                     i_SPI_ENA,
  input  logic                     i_SPI_DAT,
  input  logic                     i_FRAME_SYNC,
  input  logic                     i_ERR_CLR,
  led_spi_cmd_ctrl_if.master       wr,
  output logic                     o_BANK,
  output logic                     o_BUSY,
  output logic                     o_ERR
);
  logic                 word_stb, ena_fall, ena_rise, partial;
  logic [BIT_WIDTH-1:0] rx_word;

  spi_word_rx #(
    .BIT_WIDTH  (BIT_WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk     (i_CLK),
    .rst     (i_RST),
    .spi_clk (i_SPI_CLK),
    .spi_ena (i_SPI_ENA),
    .spi_dat (i_SPI_DAT),
    .word_stb(word_stb),
    .word    (rx_word),
    .ena_fall(ena_fall),
    .ena_rise(ena_rise),
    .partial (partial)
  );

  state_t               state_reg;
  logic [ADDR_W-1:0]    addr_reg;
  logic                 bank_reg, back_bank_reg, swap_pending_reg, err_reg;
  logic                 wr_en_reg;
  logic [ADDR_W:0]      wr_addr_reg;
  logic [BIT_WIDTH-1:0] wr_data_reg;

  opcode_t opcode;
  logic    hdr_done, err_set, swap_set;

  always_comb begin
    opcode   = rx_word[OPC_MSB:OPC_LSB];
    hdr_done = (state_reg == ST_HDR) && word_stb && !ena_rise;
    swap_set = hdr_done && (opcode == OP_SWAP);
    err_set  = (ena_rise && partial) ||
               (hdr_done && (opcode != OP_NOP) && (opcode != OP_WRITE) &&
                (opcode != OP_SWAP));
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_reg        <= ST_IDLE;
      addr_reg         <= '0;
      bank_reg         <= 1'b0;
      back_bank_reg    <= 1'b0;
      swap_pending_reg <= 1'b0;
      err_reg          <= 1'b0;
      wr_en_reg        <= 1'b0;
      wr_addr_reg      <= '0;
      wr_data_reg      <= '0;
    end else begin
      // Set has priority over clear
      err_reg <= err_set | (err_reg & ~i_ERR_CLR);
      // A SWAP finishing on the sync cycle stays pending for the next sync
      swap_pending_reg <= swap_set | (swap_pending_reg & ~i_FRAME_SYNC);
      if (i_FRAME_SYNC && swap_pending_reg)
        bank_reg <= ~bank_reg;

      wr_en_reg <= 1'b0;
      if (ena_rise) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (ena_fall) begin
              state_reg     <= ST_HDR;
              // Freeze the target bank so a mid-transaction swap
              // cannot split one transaction across banks
              back_bank_reg <= ~bank_reg;
            end
          end
          ST_HDR: begin
            if (word_stb) begin
              if (opcode == OP_WRITE) begin
                addr_reg  <= rx_word[ADDR_W-1:0];
                state_reg <= ST_DATA;
              end else begin
                state_reg <= ST_DRAIN;
              end
            end
          end
          ST_DATA: begin
            if (word_stb) begin
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= {back_bank_reg, addr_reg};
              wr_data_reg <= rx_word;
              addr_reg    <= addr_reg + ADDR_W'(1);
            end
          end
          default: ;  // ST_DRAIN ignores all bits until ENA rises
        endcase
      end
    end
  end

  assign wr.o_WR_EN   = wr_en_reg;
  assign wr.o_WR_ADDR = wr_addr_reg;
  assign wr.o_WR_DATA = wr_data_reg;
  assign o_BANK       = bank_reg;
  assign o_BUSY       = (state_reg != ST_IDLE);
  assign o_ERR        = err_reg;
endmodule
